// File: rtl/seq_alu.sv
// seq_alu: multi-cycle ALU sitting between the register file and writeback.
// Single-cycle ops (ADD, XOR, MOV, SEQ, SNE, MSK) complete one cycle after
// Start. Shifts and rotates (LSL, LSR, ASR, ROL, ROR) move one bit per cycle
// under a down-counter, so no barrel shifter is needed at large widths.
//
// Ports:
//   i_clk    clock, all state updates on the rising edge
//   i_reset  synchronous active-high reset
//   i_start  request a new op (accepted in IDLE or DONE)
//   i_op     opcode, sampled with i_start
//   i_a      operand A
//   i_b      operand B
//   i_amt    shift/rotate count
//   i_imm    compare immediate for SEQ/SNE
//   i_sc     carry in (ADD only)
//   o_busy   high while a shift/rotate iterates
//   o_done   one-cycle pulse when o_out and flags are valid
//   o_out    registered result, held until the next completion
//   o_sc     carry out, or last bit shifted out
//   o_zero   ~|o_out
//   o_parity ^o_out
//   o_odd    o_out[0]
//   o_err    illegal opcode flag
//
// state | meaning
// IDLE  | waiting for Start; result and flags hold
// SHIFT | iterating a shift/rotate, one bit per cycle
// DONE  | result valid, Done pulse; Start accepted here too

module seq_alu #(
  parameter int W  = 8,
  parameter int CW = $clog2(W)
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [3:0]    i_op,
  input  logic [W-1:0]  i_a,
  input  logic [W-1:0]  i_b,
  input  logic [CW-1:0] i_amt,
  input  logic [W-1:0]  i_imm,
  input  logic          i_sc,
  output logic          o_busy,
  output logic          o_done,
  output logic [W-1:0]  o_out,
  output logic          o_sc,
  output logic          o_zero,
  output logic          o_parity,
  output logic          o_odd,
  output logic          o_err
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_LSL = 4'd1;
  localparam logic [3:0] OP_LSR = 4'd2;
  localparam logic [3:0] OP_ASR = 4'd3;
  localparam logic [3:0] OP_ROL = 4'd4;
  localparam logic [3:0] OP_ROR = 4'd5;
  localparam logic [3:0] OP_XOR = 4'd6;
  localparam logic [3:0] OP_MOV = 4'd7;
  localparam logic [3:0] OP_SEQ = 4'd8;
  localparam logic [3:0] OP_SNE = 4'd9;
  localparam logic [3:0] OP_MSK = 4'd10;

  localparam logic [W-1:0] LP_W   = W'(W);
  localparam logic [W-1:0] LP_ONE = W'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  state_t         r_state;
  logic [W-1:0]   r_out;
  logic           r_sc;
  logic           r_zero;
  logic           r_parity;
  logic           r_odd;
  logic           r_err;
  logic           r_busy;
  logic           r_done;
  logic [CW-1:0]  r_count;
  logic [3:0]     r_kind;

  logic           w_accept;
  logic           w_is_shift;
  logic           w_illegal;
  logic [W:0]     w_add;
  logic [W-1:0]   w_single;
  logic           w_single_sc;
  logic [W-1:0]   w_step;
  logic           w_step_sc;
  logic           w_load;
  logic [W-1:0]   w_nxt_out;
  logic           w_nxt_sc;

  // Start is ignored only while a shift is iterating.
  assign w_accept   = i_start && (r_state != S_SHIFT);
  assign w_is_shift = (i_op >= OP_LSL) && (i_op <= OP_ROR);
  assign w_illegal  = (i_op > OP_MSK);
  assign w_add      = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_sc};

  always_comb begin
    w_single    = '0;
    w_single_sc = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_single    = w_add[W-1:0];
        w_single_sc = w_add[W];
      end
      OP_XOR: w_single = i_a ^ i_b;
      OP_MOV: w_single = i_b;
      OP_SEQ: w_single = {{(W-1){1'b0}}, (i_a == i_imm)};
      OP_SNE: w_single = {{(W-1){1'b0}}, (i_a != i_imm)};
      OP_MSK: w_single = (i_b < LP_W) ? (LP_ONE << i_b) : '0;
      default: w_single = '0;
    endcase
  end

  // One-bit step of the shift held in r_kind; the carry is the bit leaving Out.
  always_comb begin
    w_step    = r_out;
    w_step_sc = 1'b0;
    case (r_kind)
      OP_LSL: begin
        w_step    = {r_out[W-2:0], 1'b0};
        w_step_sc = r_out[W-1];
      end
      OP_LSR: begin
        w_step    = {1'b0, r_out[W-1:1]};
        w_step_sc = r_out[0];
      end
      OP_ASR: begin
        w_step    = {r_out[W-1], r_out[W-1:1]};
        w_step_sc = r_out[0];
      end
      OP_ROL: begin
        w_step    = {r_out[W-2:0], r_out[W-1]};
        w_step_sc = r_out[W-1];
      end
      OP_ROR: begin
        w_step    = {r_out[0], r_out[W-1:1]};
        w_step_sc = r_out[0];
      end
      default: begin
        w_step    = r_out;
        w_step_sc = 1'b0;
      end
    endcase
  end

  // Next Out/carry; flags are derived from w_nxt_out so they always track Out.
  always_comb begin
    w_load    = 1'b0;
    w_nxt_out = r_out;
    w_nxt_sc  = r_sc;
    if (w_accept) begin
      w_load = 1'b1;
      if (w_is_shift) begin
        w_nxt_out = i_a;
        w_nxt_sc  = 1'b0;
      end else begin
        w_nxt_out = w_single;
        w_nxt_sc  = w_single_sc;
      end
    end else if (r_state == S_SHIFT) begin
      w_load    = 1'b1;
      w_nxt_out = w_step;
      w_nxt_sc  = w_step_sc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= S_IDLE;
      r_out    <= '0;
      r_sc     <= 1'b0;
      r_zero   <= 1'b1;
      r_parity <= 1'b0;
      r_odd    <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_count  <= '0;
      r_kind   <= OP_ADD;
    end else begin
      if (w_load) begin
        r_out    <= w_nxt_out;
        r_sc     <= w_nxt_sc;
        r_zero   <= ~|w_nxt_out;
        r_parity <= ^w_nxt_out;
        r_odd    <= w_nxt_out[0];
      end

      if (w_accept) begin
        r_err <= w_illegal;
        if (w_is_shift && (i_amt != '0)) begin
          r_state <= S_SHIFT;
          r_busy  <= 1'b1;
          r_done  <= 1'b0;
          r_count <= i_amt;
          r_kind  <= i_op;
        end else begin
          r_state <= S_DONE;
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_count <= '0;
        end
      end else begin
        case (r_state)
          S_SHIFT: begin
            r_count <= r_count - 1'b1;
            // The step taken on this edge is the last one when count is 1.
            if (r_count == CW'(1)) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end
          S_DONE: begin
            r_state <= S_IDLE;
            r_done  <= 1'b0;
          end
          default: begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_out    = r_out;
  assign o_sc     = r_sc;
  assign o_zero   = r_zero;
  assign o_parity = r_parity;
  assign o_odd    = r_odd;
  assign o_err    = r_err;

endmodule

// File: tb/tb_seq_alu.sv
module tb_seq_alu;

  localparam int W  = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [3:0]    op;
  logic [W-1:0]  a, b, imm;
  logic [CW-1:0] amt;
  logic          sc_in;
  logic          busy, done, sc_out, zero, parity, odd, err;
  logic [W-1:0]  out;

  seq_alu #(.W(W), .CW(CW)) dut (
    .i_clk(clk), .i_reset(rst), .i_start(start), .i_op(op),
    .i_a(a), .i_b(b), .i_amt(amt), .i_imm(imm), .i_sc(sc_in),
    .o_busy(busy), .o_done(done), .o_out(out), .o_sc(sc_out),
    .o_zero(zero), .o_parity(parity), .o_odd(odd), .o_err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] out;
    logic         sc;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc     = 0;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Monitor: samples 1 time unit after each rising edge and checks every Done.
  always @(posedge clk) begin
    exp_t e;
    logic ez, ep, eo;
    cyc++;
    #1;
    if (done) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_done cycle=%0d out=%h", cyc, out);
      end else begin
        e  = exp_q.pop_front();
        ez = ~|e.out;
        ep = ^e.out;
        eo = e.out[0];
        if (out !== e.out || sc_out !== e.sc || err !== e.err || zero !== ez ||
            parity !== ep || odd !== eo || cyc != e.cyc) begin
          n_fail++;
          $display("FAIL %s got out=%h sc=%b err=%b z=%b p=%b o=%b cyc=%0d want out=%h sc=%b err=%b z=%b p=%b o=%b cyc=%0d",
                   e.name, out, sc_out, err, zero, parity, odd, cyc,
                   e.out, e.sc, e.err, ez, ep, eo, e.cyc);
        end
      end
    end
  end

  task automatic drive(input string nm, input logic [3:0] o, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic [CW-1:0] iamt,
                       input logic [W-1:0] iimm, input logic isc, input bit push,
                       input int delay, input logic [W-1:0] eout, input logic esc,
                       input logic eerr);
    exp_t e;
    op = o; a = ia; b = ib; amt = iamt; imm = iimm; sc_in = isc; start = 1'b1;
    if (push) begin
      e.name = nm; e.out = eout; e.sc = esc; e.err = eerr; e.cyc = cyc + delay;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle(input string nm);
    bit ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !busy && !done) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL timeout_%s pending=%0d busy=%b", nm, exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic run_op(input string nm, input logic [3:0] o, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic [CW-1:0] iamt,
                        input logic [W-1:0] iimm, input logic isc, input int delay,
                        input logic [W-1:0] eout, input logic esc, input logic eerr);
    @(negedge clk);
    drive(nm, o, ia, ib, iamt, iimm, isc, 1'b1, delay, eout, esc, eerr);
    @(negedge clk);
    start = 1'b0;
    wait_idle(nm);
  endtask

  task automatic check1(input string nm, input logic got, input logic want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%b want=%b", nm, got, want);
    end
  endtask

  task automatic check_out(input string nm, input logic [W-1:0] want);
    n_tests++;
    if (out !== want) begin
      n_fail++;
      $display("FAIL %s got=%h want=%h", nm, out, want);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; imm = '0; amt = '0; sc_in = 1'b0;
    repeat (3) @(negedge clk);
    check_out("reset_out", 8'h00);
    check1("reset_zero", zero, 1'b1);
    check1("reset_parity", parity, 1'b0);
    check1("reset_odd", odd, 1'b0);
    check1("reset_busy", busy, 1'b0);
    check1("reset_done", done, 1'b0);
    check1("reset_err", err, 1'b0);
    check1("reset_sc", sc_out, 1'b0);
    rst = 1'b0;

    // LSL Amt=5 aborted by reset in its second cycle: no Done may appear.
    @(negedge clk);
    drive("lsl_abort", 4'd1, 8'h13, 8'h00, 3'd5, 8'h00, 1'b0, 1'b0, 0, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    check1("abort_busy_before", busy, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_out("abort_out", 8'h00);
    check1("abort_zero", zero, 1'b1);
    check1("abort_busy", busy, 1'b0);
    check1("abort_done", done, 1'b0);

    run_op("add_3_4",   4'd0, 8'h03, 8'h04, 3'd0, 8'h00, 1'b0, 1, 8'h07, 1'b0, 1'b0);
    run_op("add_carry", 4'd0, 8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1, 8'h01, 1'b1, 1'b0);

    // ASR 0x90 by 3, with ignored Start pulses while Busy.
    @(negedge clk);
    drive("asr_90_3", 4'd3, 8'h90, 8'h00, 3'd3, 8'h00, 1'b0, 1'b1, 4, 8'hF2, 1'b0, 1'b0);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check1("asr_busy", busy, 1'b1);
      if (k < 3) begin
        op = 4'd0; a = 8'h11; b = 8'h22; start = 1'b1;
      end else begin
        start = 1'b0;
      end
    end
    wait_idle("asr_90_3");

    run_op("rol_81_1",  4'd4, 8'h81, 8'h00, 3'd1, 8'h00, 1'b0, 2, 8'h03, 1'b1, 1'b0);
    run_op("lsr_81_0",  4'd2, 8'h81, 8'h00, 3'd0, 8'h00, 1'b0, 1, 8'h81, 1'b0, 1'b0);
    run_op("lsl_81_7",  4'd1, 8'h81, 8'h00, 3'd7, 8'h00, 1'b0, 8, 8'h80, 1'b0, 1'b0);
    run_op("ror_01_1",  4'd5, 8'h01, 8'h00, 3'd1, 8'h00, 1'b0, 2, 8'h80, 1'b1, 1'b0);
    run_op("mov_5a",    4'd7, 8'h33, 8'h5A, 3'd0, 8'h00, 1'b1, 1, 8'h5A, 1'b0, 1'b0);

    // SEQ then SNE issued in SEQ's Done cycle.
    @(negedge clk);
    drive("seq_2a", 4'd8, 8'h2A, 8'h00, 3'd0, 8'h2A, 1'b0, 1'b1, 1, 8'h01, 1'b0, 1'b0);
    @(negedge clk);
    check1("seq_done_b2b", done, 1'b1);
    drive("sne_2a", 4'd9, 8'h2A, 8'h00, 3'd0, 8'h2A, 1'b0, 1'b1, 1, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_idle("seq_sne");

    run_op("msk_6",     4'd10, 8'h00, 8'h06, 3'd0, 8'h00, 1'b0, 1, 8'h40, 1'b0, 1'b0);
    run_op("msk_9",     4'd10, 8'h00, 8'h09, 3'd0, 8'h00, 1'b0, 1, 8'h00, 1'b0, 1'b0);
    run_op("asr_81_2",  4'd3, 8'h81, 8'h00, 3'd2, 8'h00, 1'b0, 3, 8'hE0, 1'b0, 1'b0);
    run_op("illegal_12",4'd12, 8'h55, 8'h66, 3'd0, 8'h00, 1'b1, 1, 8'h00, 1'b0, 1'b1);
    check1("err_holds_idle", err, 1'b1);
    run_op("xor_f0_ff", 4'd6, 8'hF0, 8'hFF, 3'd0, 8'h00, 1'b0, 1, 8'h0F, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check_out("hold_idle", 8'h0F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
